// File: rtl/uart_word_rx.sv
// Byte-to-word receive framer: synchronises the uart byte strobe, checks
// header/payload/XOR-checksum framing and hands out one word per good frame.
module uart_word_rx #(
   parameter int         WORD_BYTES  = 4,
   parameter logic [7:0] HEADER      = 8'hA5,
   parameter int         TIMEOUT_CYC = 65535
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    read_done,
   input  logic [7:0]              read_data,
   output logic [8*WORD_BYTES-1:0] data,
   output logic                    valid,
   input  logic                    ack,
   output logic                    err,
   output logic                    overrun,
   output logic [3:0]              sta
);

   localparam int              DW        = 8 * WORD_BYTES;
   localparam int              CW        = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [CW-1:0]   LAST_IDX  = CW'(WORD_BYTES - 1);
   localparam logic [15:0]     TIMEOUT_V = 16'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2,
      HOLD    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            sync1_q, sync2_q, sync3_q;
   logic            strobe_q, strobe_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      chk_q, chk_d;
   logic [15:0]     timer_q, timer_d;
   logic [DW-1:0]   shift_q, shift_d;
   logic [DW-1:0]   data_q, data_d;
   logic            err_q, err_d;
   logic            overrun_q, overrun_d;

   // Registered edge detect puts the strobe 3 clk after read_done rises.
   always_comb begin
      strobe_d = sync2_q & ~sync3_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         sync3_q   <= 1'b0;
         strobe_q  <= 1'b0;
         state_q   <= IDLE;
         count_q   <= '0;
         chk_q     <= '0;
         timer_q   <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         err_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         sync1_q   <= read_done;
         sync2_q   <= sync1_q;
         sync3_q   <= sync2_q;
         strobe_q  <= strobe_d;
         state_q   <= state_d;
         count_q   <= count_d;
         chk_q     <= chk_d;
         timer_q   <= timer_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         err_q     <= err_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      chk_d     = chk_q;
      timer_d   = timer_q;
      shift_d   = shift_q;
      data_d    = data_q;
      err_d     = 1'b0;
      overrun_d = overrun_q;
      case (state_q)
         IDLE: begin
            if (strobe_q && (read_data == HEADER)) begin
               state_d = PAYLOAD;
               count_d = '0;
               chk_d   = '0;
               timer_d = '0;
            end
         end
         PAYLOAD: begin
            if (strobe_q) begin
               for (int i = 0; i < WORD_BYTES; i++) begin
                  if (count_q == CW'(i)) shift_d[8*i +: 8] = read_data;
               end
               chk_d   = chk_q ^ read_data;
               timer_d = '0;
               if (count_q == LAST_IDX) state_d = CHECK;
               else                     count_d = count_q + CW'(1);
            end else if (timer_q == TIMEOUT_V) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         CHECK: begin
            if (strobe_q) begin
               timer_d = '0;
               if (read_data == chk_q) begin
                  state_d = HOLD;
                  data_d  = shift_q;
               end else begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
            end else if (timer_q == TIMEOUT_V) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         HOLD: begin
            // A byte arriving before the consumer acks is lost, even alongside ack.
            if (strobe_q) overrun_d = 1'b1;
            if (ack)      state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      valid   = (state_q == HOLD);
      sta     = {2'b00, state_q};
      data    = data_q;
      err     = err_q;
      overrun = overrun_q;
   end

endmodule

// File: tb/tb_uart_word_rx.sv
// Bench for uart_word_rx: frame vector table, directed corner sequences and a
// random byte stream checked against a queue-based frame model.
module tb_uart_word_rx;

   localparam int TO = 200;

   logic        clk;
   logic        rst;
   logic        read_done;
   logic [7:0]  read_data;
   logic [31:0] data;
   logic        valid;
   logic        ack;
   logic        err;
   logic        overrun;
   logic [3:0]  sta;

   int n_tests;
   int n_fail;
   int err_cnt;

   uart_word_rx #(.WORD_BYTES(4), .HEADER(8'hA5), .TIMEOUT_CYC(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .read_done (read_done),
      .read_data (read_data),
      .data      (data),
      .valid     (valid),
      .ack       (ack),
      .err       (err),
      .overrun   (overrun),
      .sta       (sta)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts clock cycles with err high, so a stretched pulse counts twice.
   always @(negedge clk) if (err === 1'b1) err_cnt++;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1);
   end

   typedef struct {
      logic [47:0] frame;
      logic        exp_valid;
      logic [31:0] exp_data;
      int          exp_err;
   } vec_t;

   vec_t vecs[8];

   // Reference model state for the random section
   logic [7:0]  m_frame[$];
   logic        m_hold;
   logic [31:0] m_word;
   int          m_err;
   logic        m_ovr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      read_data = b;
      read_done = 1'b1;
      repeat (4) @(negedge clk);
      read_done = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_ack();
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   task automatic send_frame6(input logic [47:0] f);
      for (int i = 0; i < 6; i++) send_byte(f[47-8*i -: 8]);
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [7:0] x;
      if (m_hold) begin
         m_ovr = 1'b1;
      end else if (m_frame.size() == 0) begin
         if (b == 8'hA5) m_frame.push_back(b);
      end else begin
         m_frame.push_back(b);
         if (m_frame.size() == 6) begin
            x = 8'h00;
            for (int i = 1; i <= 4; i++) x = x ^ m_frame[i];
            if (x == m_frame[5]) begin
               m_word = {m_frame[4], m_frame[3], m_frame[2], m_frame[1]};
               m_hold = 1'b1;
            end else begin
               m_err++;
            end
            m_frame.delete();
         end
      end
   endtask

   function automatic logic [3:0] model_sta();
      if (m_hold)                return 4'd3;
      if (m_frame.size() == 0)   return 4'd0;
      if (m_frame.size() <= 4)   return 4'd1;
      return 4'd2;
   endfunction

   task automatic rand_byte(input logic [7:0] b, input int err_base);
      send_byte(b);
      model_byte(b);
      check("rnd_sta",     32'(sta),              32'(model_sta()));
      check("rnd_valid",   32'(valid),            32'(m_hold));
      check("rnd_data",    data,                  m_word);
      check("rnd_err",     32'(err_cnt - err_base), 32'(m_err));
      check("rnd_overrun", 32'(overrun),          32'(m_ovr));
   endtask

   initial begin
      int          e0;
      logic [31:0] last;
      logic [7:0]  p[4];
      logic [7:0]  c;
      int          kind;
      int          err_base;

      n_tests   = 0;
      n_fail    = 0;
      err_cnt   = 0;
      rst       = 1'b0;
      read_done = 1'b0;
      read_data = 8'h00;
      ack       = 1'b0;

      vecs[0] = '{48'hA5_11_22_33_44_44, 1'b1, 32'h44332211, 0};
      vecs[1] = '{48'hA5_11_22_33_44_00, 1'b0, 32'h44332211, 1};
      vecs[2] = '{48'hA5_AA_BB_CC_DD_00, 1'b1, 32'hDDCCBBAA, 0};
      vecs[3] = '{48'hA5_A5_A5_A5_A5_00, 1'b1, 32'hA5A5A5A5, 0};
      vecs[4] = '{48'hA5_12_34_56_78_08, 1'b1, 32'h78563412, 0};
      vecs[5] = '{48'hA5_12_34_56_78_09, 1'b0, 32'h78563412, 1};
      vecs[6] = '{48'hA5_FF_00_FF_00_00, 1'b1, 32'h00FF00FF, 0};
      vecs[7] = '{48'hA5_80_00_00_01_81, 1'b1, 32'h01000080, 0};

      repeat (3) @(negedge clk);
      check("rst_data",    data,           32'h0);
      check("rst_valid",   32'(valid),     32'h0);
      check("rst_err",     32'(err),       32'h0);
      check("rst_overrun", 32'(overrun),   32'h0);
      check("rst_sta",     32'(sta),       32'h0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Good frame with valid latency measured from read_done rise
      e0 = err_cnt;
      send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      send_byte(8'h44);
      check("t1_sta_check", 32'(sta), 32'd2);
      @(negedge clk);
      read_data = 8'h44;
      read_done = 1'b1;
      repeat (3) @(negedge clk);
      check("t1_valid_early", 32'(valid), 32'h0);
      @(negedge clk);
      check("t1_valid_lat", 32'(valid), 32'h1);
      read_done = 1'b0;
      repeat (3) @(negedge clk);
      check("t1_data", data, 32'h44332211);
      check("t1_sta_hold", 32'(sta), 32'd3);
      do_ack();
      check("t1_valid_ack", 32'(valid), 32'h0);
      check("t1_sta_idle", 32'(sta), 32'd0);
      check("t1_no_err", 32'(err_cnt - e0), 32'd0);

      // Frame vector table
      last = 32'h44332211;
      for (int v = 0; v < 8; v++) begin
         e0 = err_cnt;
         send_frame6(vecs[v].frame);
         check($sformatf("vec%0d_valid", v), 32'(valid), 32'(vecs[v].exp_valid));
         check($sformatf("vec%0d_data", v), data, vecs[v].exp_valid ? vecs[v].exp_data : last);
         check($sformatf("vec%0d_sta", v), 32'(sta), vecs[v].exp_valid ? 32'd3 : 32'd0);
         check($sformatf("vec%0d_err", v), 32'(err_cnt - e0), 32'(vecs[v].exp_err));
         if (vecs[v].exp_valid) begin
            last = vecs[v].exp_data;
            do_ack();
            check($sformatf("vec%0d_ack", v), 32'(valid), 32'h0);
         end
      end

      // Leading junk bytes are ignored without err
      e0 = err_cnt;
      send_byte(8'h00);
      send_byte(8'hFF);
      check("t3_junk_sta", 32'(sta), 32'd0);
      send_frame6(48'hA5_01_02_03_04_04);
      check("t3_data", data, 32'h04030201);
      check("t3_valid", 32'(valid), 32'h1);
      check("t3_err", 32'(err_cnt - e0), 32'd0);
      do_ack();

      // Inter-byte timeout
      e0 = err_cnt;
      send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22);
      repeat (TO - 20) @(negedge clk);
      check("t4_pre_err", 32'(err_cnt - e0), 32'd0);
      check("t4_pre_sta", 32'(sta), 32'd1);
      repeat (30) @(negedge clk);
      check("t4_err_once", 32'(err_cnt - e0), 32'd1);
      check("t4_sta", 32'(sta), 32'd0);
      check("t4_valid", 32'(valid), 32'h0);
      send_frame6(48'hA5_01_00_00_00_01);
      check("t4_data", data, 32'h00000001);
      check("t4_valid_after", 32'(valid), 32'h1);
      do_ack();

      // Overrun while holding an unacked word
      send_frame6(48'hA5_AA_BB_CC_DD_00);
      check("t5_ovr_before", 32'(overrun), 32'h0);
      send_byte(8'hA5);
      check("t5_ovr", 32'(overrun), 32'h1);
      check("t5_data_kept", data, 32'hDDCCBBAA);
      check("t5_sta_hold", 32'(sta), 32'd3);
      do_ack();
      check("t5_sta_idle", 32'(sta), 32'd0);
      check("t5_ovr_sticky", 32'(overrun), 32'h1);
      send_frame6(48'hA5_01_02_03_04_04);
      do_ack();
      check("t5_ovr_sticky2", 32'(overrun), 32'h1);

      // Asynchronous reset in the middle of a payload
      send_byte(8'hA5); send_byte(8'h11);
      check("t6_sta_payload", 32'(sta), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("t6_data", data, 32'h0);
      check("t6_valid", 32'(valid), 32'h0);
      check("t6_overrun", 32'(overrun), 32'h0);
      check("t6_err", 32'(err), 32'h0);
      check("t6_sta", 32'(sta), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      send_frame6(48'hA5_AA_BB_CC_DD_00);
      check("t6_after_data", data, 32'hDDCCBBAA);
      check("t6_after_valid", 32'(valid), 32'h1);
      do_ack();

      // Random byte stream against the frame model
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      m_frame.delete();
      m_hold   = 1'b0;
      m_word   = 32'h0;
      m_err    = 0;
      m_ovr    = 1'b0;
      err_base = err_cnt;
      for (int f = 0; f < 25; f++) begin
         kind = int'($urandom_range(0, 9));
         if (kind < 2) begin
            c = 8'($urandom_range(0, 255));
            if (c == 8'hA5) c = 8'h00;
            rand_byte(c, err_base);
         end else begin
            c = 8'h00;
            for (int i = 0; i < 4; i++) begin
               p[i] = 8'($urandom_range(0, 255));
               c = c ^ p[i];
            end
            if (kind < 4) c = c ^ (8'h01 << $urandom_range(0, 7));
            rand_byte(8'hA5, err_base);
            for (int i = 0; i < 4; i++) rand_byte(p[i], err_base);
            rand_byte(c, err_base);
         end
         if (m_hold && ($urandom_range(0, 3) != 0)) begin
            do_ack();
            m_hold = 1'b0;
            check("rnd_ack_valid", 32'(valid), 32'h0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
